// File: rtl/fetch_pkg.sv
// ============================================================================
// Module   : fetch_pkg
// Brief    : Shared defaults and state type for the instruction fetch stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

  localparam int          WORD_SIZE  = 32;
  localparam int          IMEM_WORDS = 1024;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

endpackage : fetch_pkg

`default_nettype wire

// File: rtl/instruction_fetch_if.sv
// ============================================================================
// Module   : instruction_fetch_if
// Brief    : Fetch-stage bus: imem address/data, decode outputs, stall/redirect.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instruction_fetch_if
  import fetch_pkg::*;
#(
  parameter int WORD_SIZE = fetch_pkg::WORD_SIZE
);

  logic                 stall_i;
  logic                 redirect_i;
  logic [WORD_SIZE-1:0] redirect_pc_i;
  logic [WORD_SIZE-1:0] imem_addr_o;
  logic [WORD_SIZE-1:0] imem_instr_i;
  logic [WORD_SIZE-1:0] instr_o;
  logic [WORD_SIZE-1:0] pc_o;
  logic                 valid_o;
  logic                 fault_o;

  modport master (
    input  stall_i, redirect_i, redirect_pc_i, imem_instr_i,
    output imem_addr_o, instr_o, pc_o, valid_o, fault_o
  );

  modport slave (
    output stall_i, redirect_i, redirect_pc_i, imem_instr_i,
    input  imem_addr_o, instr_o, pc_o, valid_o, fault_o
  );

endinterface : instruction_fetch_if

`default_nettype wire

// File: rtl/fetch_next_pc.sv
// ============================================================================
// Module   : fetch_next_pc
// Brief    : Combinational next-PC, memory address select and fault flags.
//            Bounds checking is enabled by defining FETCH_BOUNDS_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_next_pc
  import fetch_pkg::*;
#(
  parameter int WORD_SIZE  = fetch_pkg::WORD_SIZE,
  parameter int IMEM_WORDS = fetch_pkg::IMEM_WORDS
) (
  input  logic                 i_stall,
  input  logic                 i_redirect,
  input  logic [WORD_SIZE-1:0] i_redirect_pc,
  input  logic [WORD_SIZE-1:0] i_pc_f,
  input  logic [WORD_SIZE-1:0] i_pc_d,
  output logic [WORD_SIZE-1:0] o_pc_f_next,
  output logic [WORD_SIZE-1:0] o_redirect_pc,
  output logic [WORD_SIZE-1:0] o_imem_addr,
  output logic                 o_misaligned,
  output logic                 o_out_of_bounds
);

  logic [WORD_SIZE-1:0] w_target;
  logic [WORD_SIZE-1:0] w_sel_pc;
  logic [WORD_SIZE-1:0] w_word;

  // A stall re-reads the word already in decode so the memory output holds.
  assign w_sel_pc = (i_stall && !i_redirect) ? i_pc_d : i_pc_f;
  assign w_word   = w_sel_pc >> 2;

`ifdef FETCH_BOUNDS_CHECK_EN
  assign w_target        = i_redirect_pc;
  assign o_misaligned    = i_redirect && (i_redirect_pc[1:0] != 2'b00);
  assign o_out_of_bounds = !i_redirect && !i_stall &&
                           ((i_pc_f >> 2) >= WORD_SIZE'(IMEM_WORDS));
  assign o_imem_addr     = w_word;
`else
  logic w_unused_lsbs;
  assign w_unused_lsbs   = ^i_redirect_pc[1:0];
  assign w_target        = {i_redirect_pc[WORD_SIZE-1:2], 2'b00};
  assign o_misaligned    = 1'b0;
  assign o_out_of_bounds = 1'b0;
  assign o_imem_addr     = w_word % WORD_SIZE'(IMEM_WORDS);
`endif

  assign o_redirect_pc = w_target;
  assign o_pc_f_next   = i_redirect ? w_target :
                         i_stall    ? i_pc_f   :
                                      i_pc_f + WORD_SIZE'(4);

endmodule : fetch_next_pc

`default_nettype wire

// File: rtl/instruction_fetch.sv
// ============================================================================
// Module   : instruction_fetch
// Brief    : Fetch stage: PC registers, in-flight tracking and RUN/FAULT FSM.
//            Optional bounds/alignment faulting via FETCH_BOUNDS_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int                   WORD_SIZE  = fetch_pkg::WORD_SIZE,
  parameter int                   IMEM_WORDS = fetch_pkg::IMEM_WORDS,
  parameter logic [WORD_SIZE-1:0] RESET_PC   = WORD_SIZE'(fetch_pkg::RESET_PC)
) (
  input  logic                clk,
  input  logic                reset,
  instruction_fetch_if.master bus
);

  logic [WORD_SIZE-1:0] r_pc_f;
  logic [WORD_SIZE-1:0] r_pc_d;
  logic                 r_valid_d;
  fetch_state_t         r_state;
  fetch_state_t         w_state_next;

  logic [WORD_SIZE-1:0] w_pc_f_next;
  logic [WORD_SIZE-1:0] w_redirect_pc;
  logic [WORD_SIZE-1:0] w_imem_addr;
  logic                 w_misaligned;
  logic                 w_out_of_bounds;
  logic                 w_valid_out;
  logic                 w_fault_out;

  fetch_next_pc #(
    .WORD_SIZE  (WORD_SIZE),
    .IMEM_WORDS (IMEM_WORDS)
  ) u_next_pc (
    .i_stall         (bus.stall_i),
    .i_redirect      (bus.redirect_i),
    .i_redirect_pc   (bus.redirect_pc_i),
    .i_pc_f          (r_pc_f),
    .i_pc_d          (r_pc_d),
    .o_pc_f_next     (w_pc_f_next),
    .o_redirect_pc   (w_redirect_pc),
    .o_imem_addr     (w_imem_addr),
    .o_misaligned    (w_misaligned),
    .o_out_of_bounds (w_out_of_bounds)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RUN:   if (w_misaligned || w_out_of_bounds) w_state_next = FAULT;
      FAULT: w_state_next = FAULT;
    endcase
  end

  always_comb begin
    w_valid_out = r_valid_d && (r_state == RUN);
`ifdef FETCH_BOUNDS_CHECK_EN
    w_fault_out = (r_state == FAULT);
`else
    w_fault_out = 1'b0;
`endif
  end

  // In FAULT every PC register freezes so pc_o keeps the offending address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc_f    <= RESET_PC;
      r_pc_d    <= RESET_PC;
      r_valid_d <= 1'b0;
    end else if (r_state == RUN) begin
      if (w_misaligned) begin
        r_pc_d    <= w_redirect_pc;
        r_valid_d <= 1'b0;
      end else if (bus.redirect_i) begin
        r_pc_f    <= w_pc_f_next;
        r_valid_d <= 1'b0;
      end else if (!bus.stall_i) begin
        if (w_out_of_bounds) begin
          r_pc_d    <= r_pc_f;
          r_valid_d <= 1'b0;
        end else begin
          r_pc_d    <= r_pc_f;
          r_valid_d <= 1'b1;
          r_pc_f    <= w_pc_f_next;
        end
      end
    end
  end

  assign bus.imem_addr_o = w_imem_addr;
  assign bus.instr_o     = bus.imem_instr_i;
  assign bus.pc_o        = r_pc_d;
  assign bus.valid_o     = w_valid_out;
  assign bus.fault_o     = w_fault_out;

endmodule : instruction_fetch

`default_nettype wire

// File: tb/tb_instruction_fetch.sv
// ============================================================================
// Module   : tb_instruction_fetch
// Brief    : Randomized self-checking bench with a transaction-level fetch model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch;
  import fetch_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  instruction_fetch_if bus ();

  instruction_fetch dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Clocked memory: word k holds k; reads past the array return a marker.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a < 32'(IMEM_WORDS)) ? a : 32'hDEAD_BEEF;
  endfunction

  always @(posedge clk) begin
    if (!reset) bus.imem_instr_i <= 32'h0;
    else        bus.imem_instr_i <= mem_word(bus.imem_addr_o);
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: the next PC to deliver and what decode currently sees.
  logic [31:0] m_fetch_pc;
  logic [31:0] m_pc;
  bit          m_valid;
  bit          m_fault;

  task automatic model_reset();
    m_fetch_pc = RESET_PC;
    m_pc       = RESET_PC;
    m_valid    = 1'b0;
    m_fault    = 1'b0;
  endtask

  task automatic model_step(input bit stall, input bit redir, input logic [31:0] tgt);
    bit bad_target;
    bit out_of_range;
    bad_target   = 1'b0;
    out_of_range = 1'b0;
`ifdef FETCH_BOUNDS_CHECK_EN
    bad_target   = (tgt % 4) != 0;
    out_of_range = (m_fetch_pc / 4) >= 32'(IMEM_WORDS);
`endif
    if (m_fault) begin
      // sticky until reset
    end else if (redir) begin
      m_valid = 1'b0;
      if (bad_target) begin
        m_fault = 1'b1;
        m_pc    = tgt;
      end else begin
        m_fetch_pc = tgt - (tgt % 4);
      end
    end else if (!stall) begin
      if (out_of_range) begin
        m_fault = 1'b1;
        m_valid = 1'b0;
        m_pc    = m_fetch_pc;
      end else begin
        m_pc       = m_fetch_pc;
        m_valid    = 1'b1;
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".valid"}, 32'(bus.valid_o), 32'(m_valid && !m_fault));
    check_eq({tag, ".pc"},    bus.pc_o,         m_pc);
    check_eq({tag, ".fault"}, 32'(bus.fault_o), 32'(m_fault));
    if (m_valid && !m_fault)
      check_eq({tag, ".instr"}, bus.instr_o, (m_pc / 4) % 32'(IMEM_WORDS));
  endtask

  task automatic step(input bit stall, input bit redir, input logic [31:0] tgt);
    bus.stall_i       = stall;
    bus.redirect_i    = redir;
    bus.redirect_pc_i = tgt;
    @(posedge clk);
    #1;
    model_step(stall, redir, tgt);
    compare_all("step");
  endtask

  // Asserts reset right after an edge, checks the immediate effect, holds over an edge.
  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    compare_all("rst_async");
    @(posedge clk);
    #1;
    compare_all("rst_hold");
    bus.stall_i    = 1'b0;
    bus.redirect_i = 1'b0;
    reset          = 1'b1;
  endtask

  initial begin
    bus.stall_i       = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;
    model_reset();
    #2;
    compare_all("por");
    check_eq("por_addr", bus.imem_addr_o, RESET_PC >> 2);
    @(posedge clk);
    #1;
    reset = 1'b1;

    repeat (3) step(1'b0, 1'b0, 32'h0);
    check_eq("seq_pc8", bus.pc_o, 32'h8);
    check_eq("seq_instr2", bus.instr_o, 32'h2);

    repeat (3) begin
      step(1'b1, 1'b0, 32'h0);
      check_eq("stall_pc", bus.pc_o, 32'h8);
      check_eq("stall_instr", bus.instr_o, 32'h2);
    end
    step(1'b0, 1'b0, 32'h0);
    check_eq("post_stall_pc", bus.pc_o, 32'hC);

    step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h40);
    check_eq("redir_bubble", 32'(bus.valid_o), 32'h0);
    step(1'b0, 1'b0, 32'h0);
    check_eq("redir_pc", bus.pc_o, 32'h40);
    check_eq("redir_instr", bus.instr_o, 32'd16);

    step(1'b1, 1'b1, 32'h20);
    check_eq("redir_stall_bubble", 32'(bus.valid_o), 32'h0);
    step(1'b0, 1'b0, 32'h0);
    check_eq("redir_stall_pc", bus.pc_o, 32'h20);

    step(1'b0, 1'b1, 32'h22);
    step(1'b0, 1'b0, 32'h0);
`ifdef FETCH_BOUNDS_CHECK_EN
    check_eq("misalign_fault", 32'(bus.fault_o), 32'h1);
    check_eq("misalign_pc", bus.pc_o, 32'h22);
`else
    check_eq("misalign_pc", bus.pc_o, 32'h20);
`endif
    step(1'b0, 1'b0, 32'h0);

    step(1'b0, 1'b1, 32'hFFFF_FFF8);
    repeat (4) step(1'b0, 1'b0, 32'h0);

    do_reset();
    repeat (5) step(1'b0, 1'b0, 32'h0);
    check_eq("pre_reset_pc", bus.pc_o, 32'h10);
    do_reset();
    check_eq("mid_reset_pc", bus.pc_o, RESET_PC);
    step(1'b0, 1'b0, 32'h0);
    check_eq("restart_pc", bus.pc_o, RESET_PC);
    check_eq("restart_valid", 32'(bus.valid_o), 32'h1);

    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 149) do_reset();
      step(($urandom % 10) < 3, ($urandom % 100) < 12,
           $urandom_range(0, 8 * IMEM_WORDS - 1));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_instruction_fetch

`default_nettype wire
